// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// -----------
// PS/2 host-to-device transmitter. Sends one command byte to a PS/2 device
// using the standard sequence: clock inhibit, request-to-send (start bit),
// device-clocked shift of 8 data bits + odd parity + stop, then device ACK.
// The open-drain PS/2 lines are driven through active-high pull-low enables.
//
// Optional build macro: PS2_TX_CLK_FILTER_EN
//   When defined, the synchronised PS/2 clock passes through an 8-sample
//   stability filter before falling edges are detected.
//
// Ports:
//   clk_25MHz    in   system clock
//   reset        in   asynchronous, active-high reset
//   write        in   single-cycle request to send tx_data (IDLE only)
//   tx_data[7:0] in   command byte, latched on an accepted write
//   ps2_clk_in   in   raw PS/2 clock line level (asynchronous)
//   ps2_data_in  in   raw PS/2 data line level (asynchronous)
//   ps2_clk_oe   out  1 pulls PS/2 clock low, 0 releases it
//   ps2_data_oe  out  1 pulls PS/2 data low, 0 releases it
//   busy         out  high from the cycle after an accepted write until done/err
//   done         out  one-cycle pulse: byte sent and ACK received
//   err          out  one-cycle pulse: NACK or timeout
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000
) (
  input  logic       clk_25MHz,
  input  logic       reset,
  input  logic       write,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES);

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_RTS       = 3'd2;
  localparam logic [2:0] ST_SHIFT     = 3'd3;
  localparam logic [2:0] ST_WAIT_ACK  = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  // Input synchronisers
  logic clk_meta_q, clk_meta_d;
  logic clk_sync_q, clk_sync_d;
  logic data_meta_q, data_meta_d;
  logic data_sync_q, data_sync_d;
  logic clk_prev_q, clk_prev_d;
  logic clk_level;
  logic fall;

  // Transmit FSM state
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [9:0]       shift_q, shift_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             timeout_hit;
  logic             abort;

  always_comb begin
    clk_meta_d  = ps2_clk_in;
    clk_sync_d  = clk_meta_q;
    data_meta_d = ps2_data_in;
    data_sync_d = data_meta_q;
  end

  // Synchroniser flops reset to the idle (released/high) line level so that
  // leaving reset never fabricates an edge.
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= clk_meta_d;
      clk_sync_q  <= clk_sync_d;
      data_meta_q <= data_meta_d;
      data_sync_q <= data_sync_d;
    end
  end

`ifdef PS2_TX_CLK_FILTER_EN
  logic       clk_filt_q, clk_filt_d;
  logic [2:0] filt_cnt_q, filt_cnt_d;

  // The filtered level flips only on the 8th consecutive synced sample that
  // disagrees with it; any agreeing sample restarts the run.
  always_comb begin
    clk_filt_d = clk_filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q != clk_filt_q) begin
      if (filt_cnt_q == 3'd7) begin
        clk_filt_d = clk_sync_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      clk_filt_q <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      clk_filt_q <= clk_filt_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  assign clk_level = clk_filt_q;
`else
  assign clk_level = clk_sync_q;
`endif

  assign clk_prev_d = clk_level;
  assign fall       = clk_prev_q & ~clk_level;

  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      clk_prev_q <= 1'b1;
    end else begin
      clk_prev_q <= clk_prev_d;
    end
  end

  // Outputs are registered and computed from the next state, so each output
  // lines up with the state it belongs to. A write in the cycle done/err is
  // pulsing is ignored even though the FSM is already back in IDLE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    clk_oe_d    = clk_oe_q;
    data_oe_d   = data_oe_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    abort       = 1'b0;
    timeout_hit = (cnt_q == TIMEOUT_LAST);

    case (state_q)
      ST_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        cnt_d     = '0;
        bit_cnt_d = '0;
        if (write && !done_q && !err_q) begin
          shift_d  = {1'b1, ~^tx_data, tx_data};
          clk_oe_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        if (cnt_q == INHIBIT_LAST) begin
          cnt_d     = '0;
          data_oe_d = 1'b1;
          state_d   = ST_RTS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Start bit stays driven low while the clock is released.
      ST_RTS: begin
        clk_oe_d  = 1'b0;
        cnt_d     = '0;
        bit_cnt_d = '0;
        state_d   = ST_SHIFT;
      end

      // A fall takes priority over the timeout terminal count.
      ST_SHIFT: begin
        if (fall) begin
          cnt_d     = '0;
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) begin
            state_d = ST_WAIT_ACK;
          end
        end else if (timeout_hit) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_WAIT_ACK: begin
        if (fall) begin
          cnt_d = '0;
          if (!data_sync_q) begin
            state_d = ST_WAIT_IDLE;
          end else begin
            abort = 1'b1;
          end
        end else if (timeout_hit) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_WAIT_IDLE: begin
        if (clk_level && data_sync_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (fall) begin
          cnt_d = '0;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // NACK and timeout share one exit: release both lines and flag err.
    if (abort) begin
      state_d   = ST_IDLE;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      busy_d    = 1'b0;
      err_d     = 1'b1;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: a PS/2 device model clocks frames out of the
// host, a queue holds the frame expected for each accepted write, and each
// scenario task compares what the device saw against that queue.
module tb_ps2_host_tx;

  localparam int P_INH = 50;
  localparam int P_TO  = 400;
  localparam int HALF  = 20;

  logic       clk_25MHz;
  logic       reset;
  logic       write;
  logic [7:0] tx_data;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       err;

  logic dev_clk;
  logic dev_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int last_pulse_cyc = -1;

  logic [9:0] exp_q[$];

  ps2_host_tx #(
    .INHIBIT_CYCLES(P_INH),
    .TIMEOUT_CYCLES(P_TO)
  ) dut (
    .clk_25MHz  (clk_25MHz),
    .reset      (reset),
    .write      (write),
    .tx_data    (tx_data),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Open-drain wired-AND of host and device on each line.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  initial clk_25MHz = 1'b0;
  always #5 clk_25MHz = ~clk_25MHz;

  always @(posedge clk_25MHz) cyc <= cyc + 1;

  always @(negedge clk_25MHz) begin
    if (done) begin
      done_cnt = done_cnt + 1;
      last_pulse_cyc = cyc;
    end
    if (err) begin
      err_cnt = err_cnt + 1;
      last_pulse_cyc = cyc;
    end
  end

  initial begin
    #600000;
    errors = errors + 1;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic send_write(input logic [7:0] d);
    @(negedge clk_25MHz);
    tx_data = d;
    write = 1'b1;
    exp_q.push_back({1'b1, ~^d, d});
    @(negedge clk_25MHz);
    write = 1'b0;
  endtask

  // Counts clock-inhibit cycles and RTS cycles; returns at the first sample
  // with the clock released after RTS.
  task automatic watch_rts(output int inh, output int rts, output int rel_cyc, output bit ok);
    inh = 0;
    rts = 0;
    rel_cyc = -1;
    ok = 1'b0;
    for (int i = 0; i < P_INH + 20; i++) begin
      if (ps2_clk_oe && !ps2_data_oe) inh++;
      else if (ps2_clk_oe && ps2_data_oe) rts++;
      else if (!ps2_clk_oe && rts > 0) begin
        ok = 1'b1;
        rel_cyc = cyc;
        break;
      end
      @(negedge clk_25MHz);
    end
  endtask

  task automatic device_shift(input int nbits, input bit glitch, output logic [9:0] bits);
    bits = '0;
    repeat (HALF) @(negedge clk_25MHz);
    if (glitch) begin
      dev_clk = 1'b0;
      repeat (3) @(negedge clk_25MHz);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk_25MHz);
    end
    for (int i = 0; i < nbits; i++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk_25MHz);
      bits[i] = ps2_data_in;
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk_25MHz);
    end
  endtask

  task automatic device_ack();
    dev_data = 1'b0;
    repeat (HALF) @(negedge clk_25MHz);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk_25MHz);
    dev_clk = 1'b1;
    repeat (4) @(negedge clk_25MHz);
    dev_data = 1'b1;
  endtask

  task automatic wait_outcome(input int limit, input int d0, input int e0,
                              output bit gd, output bit ge, output int at);
    for (int i = 0; i < limit; i++) begin
      if (done_cnt != d0 || err_cnt != e0) break;
      @(negedge clk_25MHz);
    end
    gd = (done_cnt != d0);
    ge = (err_cnt != e0);
    at = last_pulse_cyc;
  endtask

  function automatic logic [9:0] pop_expected();
    logic [9:0] e;
    e = 10'h3FF;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    write = 1'b0;
    tx_data = 8'h00;
    dev_clk = 1'b1;
    dev_data = 1'b1;
    repeat (3) @(negedge clk_25MHz);
    checks++; if (ps2_clk_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_clk_oe: got %b want 0", ps2_clk_oe); end
    checks++; if (ps2_data_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_data_oe: got %b want 0", ps2_data_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulses: got done=%b err=%b want 0 0", done, err); end
    reset = 1'b0;
    repeat (3) @(negedge clk_25MHz);
    checks++; if (busy !== 1'b0 || ps2_clk_oe !== 1'b0) begin errors++; $display("[TB] FAIL idle_after_reset: got busy=%b clk_oe=%b want 0 0", busy, ps2_clk_oe); end
  endtask

  // Full transfer with ACK; checks inhibit length, RTS, frame bits and done.
  task automatic test_transfer(input logic [7:0] d, input bit glitch);
    int inh, rts, rel, at, d0, e0;
    bit ok, gd, ge;
    logic [9:0] bits, exp;
    d0 = done_cnt;
    e0 = err_cnt;
    send_write(d);
    watch_rts(inh, rts, rel, ok);
    checks++; if (inh !== P_INH) begin errors++; $display("[TB] FAIL inhibit_len %h: got %0d want %0d", d, inh, P_INH); end
    checks++; if (rts !== 1 || !ok) begin errors++; $display("[TB] FAIL rts_len %h: got %0d ok=%b want 1", d, rts, ok); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_during %h: got %b want 1", d, busy); end
    device_shift(10, glitch, bits);
    device_ack();
    wait_outcome(200, d0, e0, gd, ge, at);
    exp = pop_expected();
    checks++; if (bits !== exp) begin errors++; $display("[TB] FAIL frame %h: got %b want %b", d, bits, exp); end
    checks++; if (!gd || ge) begin errors++; $display("[TB] FAIL outcome %h: got done=%b err=%b want 1 0", d, gd, ge); end
    repeat (2) @(negedge clk_25MHz);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_after %h: got %b want 0", d, busy); end
  endtask

  task automatic test_nack();
    int inh, rts, rel, d0;
    bit ok, seen, seen_done;
    logic [9:0] bits, exp;
    d0 = done_cnt;
    seen = 1'b0;
    seen_done = 1'b0;
    send_write(8'h3A);
    watch_rts(inh, rts, rel, ok);
    device_shift(10, 1'b0, bits);
    exp = pop_expected();
    checks++; if (bits !== exp) begin errors++; $display("[TB] FAIL nack_frame: got %b want %b", bits, exp); end
    dev_clk = 1'b0;
    for (int i = 0; i < HALF && !seen; i++) begin
      @(negedge clk_25MHz);
      if (err) begin
        seen = 1'b1;
        seen_done = done;
      end
    end
    checks++; if (!seen || seen_done) begin errors++; $display("[TB] FAIL nack_err: got err=%b done=%b want 1 0", seen, seen_done); end
    @(negedge clk_25MHz);
    checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin errors++; $display("[TB] FAIL nack_release: got clk_oe=%b data_oe=%b want 0 0", ps2_clk_oe, ps2_data_oe); end
    dev_clk = 1'b1;
    repeat (HALF) @(negedge clk_25MHz);
    checks++; if (done_cnt !== d0) begin errors++; $display("[TB] FAIL nack_no_done: got %0d done pulses want 0", done_cnt - d0); end
  endtask

  task automatic test_timeout();
    int inh, rts, rel, at, d0, e0;
    bit ok, gd, ge;
    logic [9:0] bits, exp;
    d0 = done_cnt;
    e0 = err_cnt;
    send_write(8'hC5);
    watch_rts(inh, rts, rel, ok);
    wait_outcome(P_TO + 50, d0, e0, gd, ge, at);
    void'(pop_expected());
    checks++; if (!ge || gd) begin errors++; $display("[TB] FAIL timeout_err: got err=%b done=%b want 1 0", ge, gd); end
    checks++; if (at - rel !== P_TO) begin errors++; $display("[TB] FAIL timeout_latency: got %0d want %0d", at - rel, P_TO); end
    repeat (5) @(negedge clk_25MHz);
    d0 = done_cnt;
    e0 = err_cnt;
    send_write(8'h96);
    watch_rts(inh, rts, rel, ok);
    device_shift(4, 1'b0, bits);
    wait_outcome(P_TO + 50, d0, e0, gd, ge, at);
    exp = pop_expected();
    checks++; if (bits[3:0] !== exp[3:0]) begin errors++; $display("[TB] FAIL stall_bits: got %b want %b", bits[3:0], exp[3:0]); end
    checks++; if (!ge || gd) begin errors++; $display("[TB] FAIL stall_err: got err=%b done=%b want 1 0", ge, gd); end
    repeat (5) @(negedge clk_25MHz);
  endtask

  task automatic test_back_to_back();
    int inh, rts, rel, at, d0, e0;
    bit ok, gd, ge;
    logic [9:0] bits, exp;
    d0 = done_cnt;
    e0 = err_cnt;
    send_write(8'hA5);
    watch_rts(inh, rts, rel, ok);
    fork
      begin
        device_shift(10, 1'b0, bits);
        device_ack();
      end
      begin
        repeat (3 * HALF) @(negedge clk_25MHz);
        tx_data = 8'h3C;
        write = 1'b1;
        @(negedge clk_25MHz);
        write = 1'b0;
      end
    join
    wait_outcome(200, d0, e0, gd, ge, at);
    exp = pop_expected();
    checks++; if (bits !== exp) begin errors++; $display("[TB] FAIL b2b_frame: got %b want %b", bits, exp); end
    checks++; if (!gd || ge) begin errors++; $display("[TB] FAIL b2b_outcome: got done=%b err=%b want 1 0", gd, ge); end
    repeat (80) @(negedge clk_25MHz);
    checks++; if (done_cnt - d0 !== 1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_single_done: got %0d pulses busy=%b want 1 0", done_cnt - d0, busy); end
  endtask

  task automatic test_write_on_done();
    int inh, rts, rel;
    bit ok, seen;
    logic [9:0] bits, exp;
    seen = 1'b0;
    send_write(8'h12);
    watch_rts(inh, rts, rel, ok);
    device_shift(10, 1'b0, bits);
    device_ack();
    for (int i = 0; i < 100 && !seen; i++) begin
      if (done) seen = 1'b1;
      else @(negedge clk_25MHz);
    end
    tx_data = 8'h77;
    write = 1'b1;
    @(negedge clk_25MHz);
    write = 1'b0;
    exp = pop_expected();
    checks++; if (!seen || bits !== exp) begin errors++; $display("[TB] FAIL wod_frame: got %b done_seen=%b want %b", bits, seen, exp); end
    repeat (5) @(negedge clk_25MHz);
    checks++; if (busy !== 1'b0 || ps2_clk_oe !== 1'b0) begin errors++; $display("[TB] FAIL wod_ignored: got busy=%b clk_oe=%b want 0 0", busy, ps2_clk_oe); end
  endtask

  task automatic test_reset_mid_shift();
    int inh, rts, rel;
    bit ok;
    logic [9:0] bits;
    send_write(8'h5A);
    watch_rts(inh, rts, rel, ok);
    device_shift(3, 1'b0, bits);
    void'(pop_expected());
    checks++; if (ps2_data_oe !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_data_oe: got %b want 1", ps2_data_oe); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (ps2_data_oe !== 1'b0 || ps2_clk_oe !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL async_reset: got data_oe=%b clk_oe=%b busy=%b want 0 0 0", ps2_data_oe, ps2_clk_oe, busy); end
    @(negedge clk_25MHz);
    reset = 1'b0;
    repeat (3) @(negedge clk_25MHz);
    test_transfer(8'h5A, 1'b0);
  endtask

  initial begin
    $display("[TB] ps2_host_tx bench start");
    test_reset();
    test_transfer(8'hF4, 1'b0);
    test_transfer(8'hFF, 1'b0);
    test_transfer(8'h00, 1'b0);
    test_nack();
    test_timeout();
    test_back_to_back();
    test_write_on_done();
    test_reset_mid_shift();
`ifdef PS2_TX_CLK_FILTER_EN
    test_transfer(8'hC3, 1'b1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
